// File: rtl/jt51_mixacc.sv
// Channel mixer/accumulator for the time-multiplexed operator pipeline.
// Sums OPS operator slots per channel, pans each channel and emits one saturated stereo frame.
module jt51_mixacc #(
    parameter int CH   = 8,
    parameter int OPS  = 4,
    parameter int OPW  = 14,
    parameter int ACCW = 16,
    parameter int OUTW = 16,
    localparam int SLOTS = CH * OPS,
    localparam int SW    = $clog2(SLOTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cen,
    input  logic                   frame_start,
    input  logic signed [OPW-1:0]  op_in,
    input  logic                   sum_en,
    input  logic [1:0]             pan,
    output logic [SW-1:0]          slot,
    output logic signed [OUTW-1:0] left,
    output logic signed [OUTW-1:0] right,
    output logic                   sample,
    output logic                   sync_err
);
    localparam int CW = $clog2(CH);
    localparam int FW = ACCW + CW;

    localparam logic signed [ACCW:0] AMAX = {2'b00, {(ACCW-1){1'b1}}};
    localparam logic signed [ACCW:0] AMIN = {2'b11, {(ACCW-1){1'b0}}};
    localparam logic signed [FW-1:0] OMAX = {{(FW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
    localparam logic signed [FW-1:0] OMIN = {{(FW-OUTW+1){1'b1}}, {(OUTW-1){1'b0}}};

    function automatic logic signed [ACCW-1:0] sat_acc(input logic signed [ACCW:0] x);
        if (x > AMAX) return AMAX[ACCW-1:0];
        if (x < AMIN) return AMIN[ACCW-1:0];
        return x[ACCW-1:0];
    endfunction

    function automatic logic signed [OUTW-1:0] sat_out(input logic signed [FW-1:0] x);
        if (x > OMAX) return OMAX[OUTW-1:0];
        if (x < OMIN) return OMIN[OUTW-1:0];
        return x[OUTW-1:0];
    endfunction

    logic [SW-1:0]          slot_q, slot_d;
    logic signed [ACCW-1:0] acc_q [CH];
    logic signed [ACCW-1:0] acc_d [CH];
    logic signed [FW-1:0]   fl_q, fl_d, fr_q, fr_d;
    logic signed [OUTW-1:0] left_q, left_d, right_q, right_d;
    logic                   sample_q, sample_d;
    logic                   sync_q, sync_d;

    logic [SW-1:0]          eff;
    logic [CW-1:0]          ch;
    logic [SW-1:0]          opn;
    logic signed [ACCW:0]   t;
    logic signed [ACCW:0]   s;
    logic signed [ACCW-1:0] v;
    logic signed [FW-1:0]   vx, base_l, base_r;

    always_comb begin
        eff  = frame_start ? '0 : slot_q;
        ch   = eff[CW-1:0];
        opn  = eff >> CW;
        t    = sum_en ? (ACCW+1)'(op_in) : '0;
        s    = (ACCW+1)'(acc_q[ch]) + t;
        v    = (opn == '0) ? t[ACCW-1:0] : sat_acc(s);
        vx   = {{CW{v[ACCW-1]}}, v};
        // First channel of the frame restarts the stereo sums, so aborted frames leave nothing behind.
        base_l = (ch == '0) ? '0 : fl_q;
        base_r = (ch == '0) ? '0 : fr_q;

        slot_d   = slot_q;
        acc_d    = acc_q;
        fl_d     = fl_q;
        fr_d     = fr_q;
        left_d   = left_q;
        right_d  = right_q;
        sample_d = 1'b0;
        sync_d   = sync_q;

        if (cen) begin
            slot_d = (eff == SW'(SLOTS-1)) ? '0 : eff + SW'(1);
            if (frame_start && slot_q != '0) sync_d = 1'b1;
            acc_d[ch] = v;
            if (opn == SW'(OPS-1)) begin
                fl_d = base_l + (pan[0] ? vx : '0);
                fr_d = base_r + (pan[1] ? vx : '0);
            end
            if (eff == SW'(SLOTS-1)) begin
                left_d   = sat_out(fl_d);
                right_d  = sat_out(fr_d);
                sample_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q   <= '0;
            fl_q     <= '0;
            fr_q     <= '0;
            left_q   <= '0;
            right_q  <= '0;
            sample_q <= 1'b0;
            sync_q   <= 1'b0;
            for (int unsigned i = 0; i < CH; i++) acc_q[i] <= '0;
        end else begin
            slot_q   <= slot_d;
            acc_q    <= acc_d;
            fl_q     <= fl_d;
            fr_q     <= fr_d;
            left_q   <= left_d;
            right_q  <= right_d;
            sample_q <= sample_d;
            sync_q   <= sync_d;
        end
    end

    assign slot     = eff;
    assign left     = left_q;
    assign right    = right_q;
    assign sample   = sample_q;
    assign sync_err = sync_q;

endmodule

// File: tb/tb_jt51_mixacc.sv
// Scoreboard bench for jt51_mixacc: driver feeds slots and a frame-level model,
// monitor pops expected stereo samples whenever the DUT strobes sample.
module tb_jt51_mixacc;
    localparam int CH = 8, OPS = 4, OPW = 14, ACCW = 16, OUTW = 16;
    localparam int SLOTS = CH * OPS;

    logic clk = 1'b0, rst = 1'b1, cen = 1'b0, frame_start = 1'b0, sum_en = 1'b0;
    logic signed [OPW-1:0] op_in = '0;
    logic [1:0] pan = '0;
    logic [4:0] slot;
    logic signed [OUTW-1:0] left, right;
    logic sample, sync_err;

    jt51_mixacc #(.CH(CH), .OPS(OPS), .OPW(OPW), .ACCW(ACCW), .OUTW(OUTW)) dut (
        .clk(clk), .rst(rst), .cen(cen), .frame_start(frame_start), .op_in(op_in),
        .sum_en(sum_en), .pan(pan), .slot(slot), .left(left), .right(right),
        .sample(sample), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int ql[$], qr[$];
    int hold_l = 0, hold_r = 0;

    // frame-level reference state
    int mslot = 0;
    int mop [SLOTS];
    bit men [SLOTS];
    bit [1:0] mpan [SLOTS];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(int x, int w);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        return (x > hi) ? hi : (x < lo) ? lo : x;
    endfunction

    // Whole-frame mix from the recorded slot table.
    task automatic model_frame();
        int l = 0, r = 0;
        for (int c = 0; c < CH; c++) begin
            int acc = 0;
            for (int o = 0; o < OPS; o++) begin
                int idx = c + o * CH;
                int tv = men[idx] ? mop[idx] : 0;
                acc = (o == 0) ? tv : clamp(acc + tv, ACCW);
            end
            if (mpan[c + (OPS-1)*CH][0]) l += acc;
            if (mpan[c + (OPS-1)*CH][1]) r += acc;
        end
        ql.push_back(clamp(l, OUTW));
        qr.push_back(clamp(r, OUTW));
    endtask

    task automatic step(bit c, bit fs, int op, bit en, bit [1:0] p);
        int eff;
        cen = c; frame_start = fs; op_in = OPW'(op); sum_en = en; pan = p;
        #1;
        if (c) begin
            eff = fs ? 0 : mslot;
            chk("slot", int'(slot), eff);
            mop[eff] = op; men[eff] = en; mpan[eff] = p;
            if (eff == SLOTS - 1) model_frame();
            mslot = (eff == SLOTS - 1) ? 0 : eff + 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic gen(int mode, int s, output int op, output bit en, output bit [1:0] p);
        int c = s % CH;
        op = int'($signed(OPW'($urandom)));
        en = 1'b0;
        p  = 2'($urandom);
        case (mode)
            0: en = ($urandom_range(0, 3) != 0);
            2: if (c == 3) begin op = 1000; en = 1; p = 2'b11; end
            3: if (c == 1) begin op = 125; en = 1; p = 2'b01; end
               else if (c == 2) begin op = -175; en = 1; p = 2'b10; end
            4: begin op = 8191; en = 1; p = 2'b11; end
            5: begin op = -8192; en = 1; p = 2'b11; end
            default: ;
        endcase
    endtask

    // Runs slots [from, to) of a frame; optional 5-clk cen gaps before slots g1/g2.
    task automatic run(int mode, int from, int to, bit fs_first, int g1, int g2, bit rgap);
        int op; bit en; bit [1:0] p;
        for (int s = from; s < to; s++) begin
            if (s == g1 || s == g2) repeat (5) step(0, 0, 0, 0, 0);
            if (rgap && $urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) step(0, 1, 77, 1, 3);
            gen(mode, s, op, en, p);
            step(1, fs_first && s == from, op, en, p);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hold_l = 0; hold_r = 0;
        ql.delete(); qr.delete();
        mslot = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sample) begin
                checks++;
                if (ql.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_sample: got sample=1 expected no sample at %0t", $time);
                end else begin
                    hold_l = ql.pop_front();
                    hold_r = qr.pop_front();
                    chk("left", int'(left), hold_l);
                    chk("right", int'(right), hold_r);
                end
            end else begin
                chk("left_hold", int'(left), hold_l);
                chk("right_hold", int'(right), hold_r);
            end
        end
    end

    initial begin
        // 1: reset and idle
        #1;
        do_reset();
        repeat (40) step(0, 0, 0, 0, 0);
        chk("idle_slot", int'(slot), 0);
        chk("idle_left", int'(left), 0);
        chk("idle_right", int'(right), 0);
        chk("idle_sample", int'(sample), 0);
        chk("idle_sync", int'(sync_err), 0);

        // 2: single channel
        run(2, 0, SLOTS, 1, -1, -1, 0);
        run(2, 0, SLOTS, 0, -1, -1, 0);
        run(2, 0, SLOTS, 1, -1, -1, 0);
        chk("t2_left", int'(left), 4000);
        chk("t2_right", int'(right), 4000);
        chk("t2_sync", int'(sync_err), 0);

        // 3: panning
        run(3, 0, SLOTS, 0, -1, -1, 0);
        chk("t3_left", int'(left), 500);
        chk("t3_right", int'(right), -700);

        // 4: clamping
        run(4, 0, SLOTS, 0, -1, -1, 0);
        chk("t4_max_l", int'(left), 32767);
        chk("t4_max_r", int'(right), 32767);
        run(5, 0, SLOTS, 0, -1, -1, 0);
        chk("t4_min_l", int'(left), -32768);
        chk("t4_min_r", int'(right), -32768);

        // 5: resync mid-frame
        run(4, 0, 10, 0, -1, -1, 0);
        run(3, 0, SLOTS, 1, -1, -1, 0);
        chk("t5_sync", int'(sync_err), 1);
        chk("t5_left", int'(left), 500);
        chk("t5_right", int'(right), -700);

        // 6: cen gaps and mid-frame reset
        run(2, 0, SLOTS, 0, 7, 31, 0);
        chk("t6_left", int'(left), 4000);
        run(3, 0, 20, 0, -1, -1, 0);
        do_reset();
        chk("rst_slot", int'(slot), 0);
        chk("rst_left", int'(left), 0);
        chk("rst_right", int'(right), 0);
        chk("rst_sample", int'(sample), 0);
        chk("rst_sync", int'(sync_err), 0);
        run(2, 0, SLOTS, 0, -1, -1, 0);
        chk("t6_rst_left", int'(left), 4000);
        chk("t6_rst_right", int'(right), 4000);

        // randomized frames with random cen gaps
        for (int f = 0; f < 60; f++) run(0, 0, SLOTS, 1'($urandom), -1, -1, 1);
        run(0, 0, 13, 0, -1, -1, 0);
        run(0, 0, SLOTS, 1, -1, -1, 1);

        repeat (3) step(0, 0, 0, 0, 0);
        chk("queue_drained", ql.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end expected finish");
        $fatal(1);
    end
endmodule
